// File: rtl/valid_pattern_generator_if.sv
// Control and valid-lane bundle between the training sequencer and the VALTRAIN generator.
// The sequencer holds the master side; the generator holds the slave side.
interface valid_pattern_generator_if #(
  parameter int CW = 8
);
  logic          enable;
  logic [1:0]    mode;
  logic          start;
  logic          stop;
  logic          data_valid;
  logic [31:0]   tvld_l;
  logic          busy;
  logic          done;
  logic [CW-1:0] iter_cnt;

  modport master (
    output enable, mode, start, stop, data_valid,
    input  tvld_l, busy, done, iter_cnt
  );

  modport slave (
    input  enable, mode, start, stop, data_valid,
    output tvld_l, busy, done, iter_cnt
  );
endinterface

// File: rtl/valid_pattern_generator.sv
// Mainband valid-lane transmitter: VALTRAIN bursts, continuous training and functional valid framing.
//   state | meaning
//   IDLE  | off, or functional framing when mode is 11
//   BURST | fixed-length VALTRAIN burst, one 0x0F0F0F0F word per clock
//   CONT  | VALTRAIN every clock until stop
//   GAP   | trailing zero words after a burst, then the done pulse
module valid_pattern_generator #(
  parameter int BURST_ITER = 128,
  parameter int GAP_WORDS  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  valid_pattern_generator_if.slave vif
);

  localparam int CW  = $clog2(BURST_ITER) + 1;
  localparam int BW  = BURST_ITER / 4;
  localparam int WCW = $clog2(BW) + 1;
  localparam int GCW = $clog2(GAP_WORDS + 1) + 1;

  localparam logic [31:0]    PATTERN   = 32'h0F0F0F0F;
  localparam logic [WCW-1:0] WORD_LOAD = WCW'(BW - 1);
  localparam logic [WCW-1:0] WORD_DEC  = WCW'(1);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'(GAP_WORDS);
  localparam logic [GCW-1:0] GAP_DEC   = GCW'(1);
  localparam logic [CW-1:0]  ITER_MAX  = '1;
  localparam logic [CW-1:0]  ITER_STEP = CW'(4);

  typedef enum logic [1:0] {IDLE, BURST, CONT, GAP} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] word_cnt, word_cnt_nxt;
  logic [GCW-1:0] gap_cnt, gap_cnt_nxt;
  logic [31:0]    tvld, tvld_nxt;
  logic           busy, busy_nxt;
  logic           done, done_nxt;
  logic [CW-1:0]  iter, iter_nxt;
  logic           abort;
  logic           start_ok;

  // Abort outranks terminal count, so a stop on the last burst or gap word suppresses done.
  assign abort    = !vif.enable || vif.stop;
  assign start_ok = vif.enable && vif.start && !vif.stop &&
                    (vif.mode == 2'b01 || vif.mode == 2'b10);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      gap_cnt  <= '0;
      tvld     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      iter     <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      tvld     <= tvld_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      iter     <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    gap_cnt_nxt  = gap_cnt;
    tvld_nxt     = '0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    iter_nxt     = iter;
    case (state)
      IDLE: begin
        if (vif.enable && vif.mode == 2'b11 && vif.data_valid) tvld_nxt = PATTERN;
        // The entered state is the latched mode; mode is not looked at again until IDLE.
        if (start_ok) begin
          state_nxt    = (vif.mode == 2'b01) ? BURST : CONT;
          word_cnt_nxt = WORD_LOAD;
          gap_cnt_nxt  = GAP_LOAD;
          iter_nxt     = '0;
        end
      end
      BURST: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          tvld_nxt = PATTERN;
          busy_nxt = 1'b1;
          iter_nxt = iter + ITER_STEP;
          if (word_cnt == '0) state_nxt = GAP;
          else word_cnt_nxt = word_cnt - WORD_DEC;
        end
      end
      CONT: begin
        if (!vif.enable) begin
          state_nxt = IDLE;
        end else if (vif.stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          tvld_nxt = PATTERN;
          busy_nxt = 1'b1;
          iter_nxt = (iter > ITER_MAX - ITER_STEP) ? ITER_MAX : iter + ITER_STEP;
        end
      end
      GAP: begin
        // Terminal count of the gap timer is the done cycle, so a zero-length gap still pulses done.
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt    = 1'b1;
          gap_cnt_nxt = gap_cnt - GAP_DEC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign vif.tvld_l   = tvld;
  assign vif.busy     = busy;
  assign vif.done     = done;
  assign vif.iter_cnt = iter;

endmodule

// File: tb/tb_valid_pattern_generator.sv
// Scoreboard bench: stimulus tasks push expected per-edge outputs, a negedge monitor pops and compares.
module tb_valid_pattern_generator;

  localparam int BURST_ITER = 128;
  localparam int GAP_WORDS  = 4;
  localparam int BW         = BURST_ITER / 4;
  localparam int CW         = $clog2(BURST_ITER) + 1;
  localparam int ITER_SAT   = (1 << CW) - 1;
  localparam logic [31:0] PAT = 32'h0F0F0F0F;

  typedef struct {
    int          cyc;
    logic [31:0] tvld;
    bit          busy;
    bit          done;
    int          iter;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_iter = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  valid_pattern_generator_if #(.CW(CW)) vif();

  valid_pattern_generator #(
    .BURST_ITER(BURST_ITER),
    .GAP_WORDS (GAP_WORDS)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .vif    (vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL slot: expectation for edge %0d only reached at edge %0d", mon_e.cyc, cyc);
      end else if (vif.tvld_l !== mon_e.tvld || vif.busy !== mon_e.busy ||
                   vif.done !== mon_e.done || vif.iter_cnt !== CW'(mon_e.iter)) begin
        errors++;
        $display("FAIL edge_%0d: got tvld=%h busy=%b done=%b iter=%0d, want tvld=%h busy=%b done=%b iter=%0d",
                 cyc, vif.tvld_l, vif.busy, vif.done, vif.iter_cnt,
                 mon_e.tvld, mon_e.busy, mon_e.done, mon_e.iter);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(logic [31:0] t, bit b, bit d, int it);
    exp_t e;
    e.cyc  = cyc + 1;
    e.tvld = t;
    e.busy = b;
    e.done = d;
    e.iter = it;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_now(string name);
    checks++;
    if (vif.tvld_l !== 32'h0 || vif.busy !== 1'b0 || vif.done !== 1'b0 || vif.iter_cnt !== '0) begin
      errors++;
      $display("FAIL %s: got tvld=%h busy=%b done=%b iter=%0d, want all zero",
               name, vif.tvld_l, vif.busy, vif.done, vif.iter_cnt);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      expect_next(32'h0, 1'b0, 1'b0, m_iter);
      step();
    end
  endtask

  // abort_at = 0: full burst; otherwise stop (or enable low) while output word abort_at is showing.
  task automatic run_burst(int abort_at, bit use_en, bit chg_mode);
    int last;
    bit ab;
    last = BW + GAP_WORDS + 1;
    vif.mode  = 2'b01;
    vif.start = 1'b1;
    m_iter    = 0;
    expect_next(32'h0, 1'b0, 1'b0, m_iter);
    step();
    vif.start = 1'b0;
    for (int j = 1; j <= last; j++) begin
      ab = (abort_at != 0) && (j == abort_at + 1);
      if (ab) begin
        m_iter = 4 * ((abort_at < BW) ? abort_at : BW);
        expect_next(32'h0, 1'b0, 1'b0, m_iter);
        if (use_en) vif.enable = 1'b0;
        else vif.stop = 1'b1;
      end else if (j <= BW) begin
        m_iter = 4 * j;
        expect_next(PAT, 1'b1, 1'b0, m_iter);
      end else if (j <= BW + GAP_WORDS) begin
        expect_next(32'h0, 1'b1, 1'b0, m_iter);
      end else begin
        expect_next(32'h0, 1'b0, 1'b1, m_iter);
      end
      if (chg_mode && j == BW / 2) vif.mode = 2'b10;
      vif.start = ($urandom_range(0, 7) == 0);
      step();
      if (ab) break;
    end
    vif.start  = 1'b0;
    vif.stop   = 1'b0;
    vif.enable = 1'b1;
    vif.mode   = 2'b00;
    idle(3);
  endtask

  task automatic run_cont(int n);
    vif.mode  = 2'b10;
    vif.start = 1'b1;
    m_iter    = 0;
    expect_next(32'h0, 1'b0, 1'b0, m_iter);
    step();
    vif.start = 1'b0;
    for (int j = 1; j <= n; j++) begin
      m_iter = (4 * j > ITER_SAT) ? ITER_SAT : 4 * j;
      expect_next(PAT, 1'b1, 1'b0, m_iter);
      vif.start = ($urandom_range(0, 7) == 0);
      step();
    end
    vif.start = 1'b0;
    vif.stop  = 1'b1;
    expect_next(32'h0, 1'b0, 1'b1, m_iter);
    step();
    vif.stop = 1'b0;
    vif.mode = 2'b00;
    idle(3);
  endtask

  task automatic run_func(int n, bit fixed);
    bit dv;
    bit en;
    bit seq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vif.mode = 2'b11;
    for (int i = 0; i < n; i++) begin
      dv = fixed ? seq[i % 4] : 1'($urandom_range(0, 1));
      en = fixed ? 1'b1 : ($urandom_range(0, 7) != 0);
      vif.data_valid = dv;
      vif.enable     = en;
      vif.start      = 1'($urandom_range(0, 1));
      expect_next((dv && en) ? PAT : 32'h0, 1'b0, 1'b0, m_iter);
      step();
    end
    vif.data_valid = 1'b0;
    vif.enable     = 1'b1;
    vif.start      = 1'b0;
    vif.mode       = 2'b00;
    idle(2);
  endtask

  task automatic run_reset_mid();
    vif.mode  = 2'b01;
    vif.start = 1'b1;
    m_iter    = 0;
    expect_next(32'h0, 1'b0, 1'b0, m_iter);
    step();
    vif.start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      m_iter = 4 * j;
      expect_next(PAT, 1'b1, 1'b0, m_iter);
      step();
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_now("reset_mid_run");
    m_iter   = 0;
    vif.mode = 2'b00;
    expect_next(32'h0, 1'b0, 1'b0, m_iter);
    step();
    rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    vif.enable     = 1'b1;
    vif.mode       = 2'b01;
    vif.start      = 1'b1;
    vif.stop       = 1'b0;
    vif.data_valid = 1'b0;
    rst_n          = 1'b0;
    #1;
    check_zero_now("reset_async");
    for (int i = 0; i < 3; i++) begin
      expect_next(32'h0, 1'b0, 1'b0, 0);
      step();
    end
    rst_n     = 1'b1;
    vif.start = 1'b0;
    vif.mode  = 2'b00;
    idle(2);

    run_burst(0, 1'b0, 1'b0);
    run_burst(10, 1'b0, 1'b0);
    run_burst(BW, 1'b0, 1'b0);
    run_burst(BW + GAP_WORDS, 1'b0, 1'b0);
    run_burst(0, 1'b0, 1'b1);
    run_burst(7, 1'b1, 1'b0);
    run_cont(100);
    run_func(8, 1'b1);
    run_func(40, 1'b0);

    vif.mode  = 2'b01;
    vif.start = 1'b1;
    vif.stop  = 1'b1;
    expect_next(32'h0, 1'b0, 1'b0, m_iter);
    step();
    vif.start = 1'b0;
    vif.stop  = 1'b0;
    vif.mode  = 2'b00;
    idle(4);

    run_reset_mid();

    for (int r = 0; r < 6; r++)
      run_burst($urandom_range(0, BW + GAP_WORDS), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_cont($urandom_range(3, 80));

    repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
